// File: rtl/bram_scan_sequencer.sv
// bram_scan_sequencer
//   Walks a two-level (inner i, outer j) index space and issues one request
//   per (i, j) pair over a valid/ready handshake. For each request it
//   presents the BRAM number {j[low bits], i}, the row j[high bits], and the
//   raw i and j indices. It raises req_last on the final request and pulses
//   done for one cycle once the scan completes.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   scan request, sampled only while idle
//   j_count    in   number of outer iterations, latched on an accepted start
//   req_valid  out  request valid
//   req_ready  in   downstream accept
//   req_bram   out  BRAM number {j[LO_W-1:0], i}
//   req_row    out  row within the BRAM, j[J_SIZE-1:LO_W]
//   req_i      out  current inner index
//   req_j      out  current outer index
//   req_last   out  final request of the scan
//   busy       out  sequencer not idle
//   done       out  one-cycle end-of-scan pulse
module bram_scan_sequencer #(
  parameter int unsigned BRAM_COUNT       = 32,
  parameter int unsigned BRAM_NUMBER_SIZE = 5,
  parameter int unsigned I_SIZE           = 3,
  parameter int unsigned J_SIZE           = 6,
  localparam int unsigned LO_W            = BRAM_NUMBER_SIZE - I_SIZE,
  localparam int unsigned ROW_W           = J_SIZE - LO_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [J_SIZE-1:0]           j_count,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [BRAM_NUMBER_SIZE-1:0] req_bram,
  output logic [ROW_W-1:0]            req_row,
  output logic [I_SIZE-1:0]           req_i,
  output logic [J_SIZE-1:0]           req_j,
  output logic                        req_last,
  output logic                        busy,
  output logic                        done
);

  // Elaboration-time parameter sanity checks.
  if (BRAM_COUNT > (1 << BRAM_NUMBER_SIZE)) begin : g_bram_count_chk
    $error("BRAM_COUNT does not fit in BRAM_NUMBER_SIZE bits");
  end
  if (J_SIZE <= LO_W) begin : g_j_size_chk
    $error("J_SIZE must exceed BRAM_NUMBER_SIZE-I_SIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [I_SIZE-1:0]   i_q, i_d;
  logic [J_SIZE-1:0]   j_q, j_d;
  logic [J_SIZE-1:0]   cnt_q, cnt_d;
  logic                i_wrap;
  logic                last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;

    i_wrap  = (i_q == '1);
    // Gated with ISSUE so a zero latched count can never alias to "last".
    last    = (state_q == S_ISSUE) && i_wrap && (j_q == cnt_q - 1'b1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = j_count;
          i_d     = '0;
          j_d     = '0;
          state_d = (j_count == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          if (last) begin
            // Indices hold on the final handshake so j never passes count-1.
            state_d = S_FINISH;
          end else begin
            i_d = i_q + 1'b1;
            if (i_wrap) begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_valid = (state_q == S_ISSUE);
  assign req_bram  = {j_q[LO_W-1:0], i_q};
  assign req_row   = j_q[J_SIZE-1:LO_W];
  assign req_i     = i_q;
  assign req_j     = j_q;
  assign req_last  = last;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_bram_scan_sequencer.sv
// tb_bram_scan_sequencer
//   Directed bench for bram_scan_sequencer with default parameters
//   (I_SIZE=3, J_SIZE=6, BRAM_NUMBER_SIZE=5): 8 inner steps per outer step,
//   BRAM number {j[1:0], i}, row j[5:2].
module tb_bram_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] j_count;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_bram;
  logic [3:0] req_row;
  logic [2:0] req_i;
  logic [5:0] req_j;
  logic       req_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  bram_scan_sequencer #(
    .BRAM_COUNT      (32),
    .BRAM_NUMBER_SIZE(5),
    .I_SIZE          (3),
    .J_SIZE          (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .j_count  (j_count),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_bram (req_bram),
    .req_row  (req_row),
    .req_i    (req_i),
    .req_j    (req_j),
    .req_last (req_last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One observation per cycle, taken 1 time unit after the rising edge.
  typedef struct {
    logic       valid;
    logic       ready;
    logic       rst;
    logic       last;
    logic       busy;
    logic       done;
    logic [4:0] bram;
    logic [3:0] row;
    logic [2:0] i;
    logic [5:0] j;
  } cyc_t;

  cyc_t log_q[$];
  cyc_t hs_q[$];
  int   hs_cyc[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [5:0] jc);
    start   = 1'b1;
    j_count = jc;
    step();
    start   = 1'b0;
  endtask

  // Runs n_cyc cycles, logging outputs. Optional: stall req_ready for
  // stall_len cycles when handshake #stall_hs is pending, pulse start with
  // j_count=7 at cycle inj_cyc, and assert reset once after rst_hs handshakes.
  task automatic run(input int n_cyc, input int stall_hs, input int stall_len,
                     input int inj_cyc, input int rst_hs);
    int   hs = 0;
    int   stalled = 0;
    bit   rst_used = 0;
    bit   rst_fire;
    cyc_t e;
    log_q.delete();
    for (int c = 0; c < n_cyc; c++) begin
      req_ready = 1'b1;
      if (hs == stall_hs && stalled < stall_len) begin
        req_ready = 1'b0;
        stalled++;
      end
      start = (c == inj_cyc);
      if (c == inj_cyc) j_count = 6'd7;
      rst_fire = (rst_hs >= 0) && (hs == rst_hs) && !rst_used;
      rst_n = !rst_fire;
      if (rst_fire) rst_used = 1;
      e.valid = req_valid; e.ready = req_ready; e.rst = rst_fire;
      e.last = req_last;   e.busy = busy;       e.done = done;
      e.bram = req_bram;   e.row = req_row;     e.i = req_i; e.j = req_j;
      log_q.push_back(e);
      if (req_valid === 1'b1 && req_ready && !rst_fire) hs++;
      step();
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic void extract();
    hs_q.delete();
    hs_cyc.delete();
    foreach (log_q[c]) begin
      if (log_q[c].valid === 1'b1 && log_q[c].ready && !log_q[c].rst) begin
        hs_q.push_back(log_q[c]);
        hs_cyc.push_back(c);
      end
    end
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (log_q[c]) if (log_q[c].done === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; j_count = '0; req_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", req_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (req_i !== 3'd0 || req_j !== 6'd0) begin n_bad++; $display("FAIL reset_ij: got i=%0d j=%0d want 0 0", req_i, req_j); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single();
    int lc;
    kick(6'd1);
    run(12, -1, 0, -1, -1);
    extract();
    n_cmp++; if (log_q[0].valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got %0b want 1", log_q[0].valid); end
    n_cmp++; if (hs_q.size() != 8) begin n_bad++; $display("FAIL single_count: got %0d want 8", hs_q.size()); end
    for (int k = 0; k < 8 && k < hs_q.size(); k++) begin
      n_cmp++;
      if (hs_q[k].bram !== 5'(k) || hs_q[k].row !== 4'd0 || hs_q[k].last !== (k == 7) || hs_cyc[k] != k) begin
        n_bad++;
        $display("FAIL single_req%0d: got bram=%0d row=%0d last=%0b cyc=%0d want bram=%0d row=0 last=%0b cyc=%0d",
                 k, hs_q[k].bram, hs_q[k].row, hs_q[k].last, hs_cyc[k], k, (k == 7), k);
      end
    end
    lc = (hs_q.size() == 8) ? hs_cyc[7] + 1 : 0;
    n_cmp++; if (log_q[lc].done !== 1'b1 || log_q[lc].valid !== 1'b0) begin n_bad++; $display("FAIL single_done: got done=%0b valid=%0b want 1 0", log_q[lc].done, log_q[lc].valid); end
    n_cmp++; if (count_done() != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", count_done()); end
    n_cmp++; if (log_q[lc+1].busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy=%0b want 0", log_q[lc+1].busy); end
  endtask

  task automatic test_multi();
    int eb, er;
    kick(6'd5);
    run(44, -1, 0, -1, -1);
    extract();
    n_cmp++; if (hs_q.size() != 40) begin n_bad++; $display("FAIL multi_count: got %0d want 40", hs_q.size()); end
    for (int k = 0; k < 40 && k < hs_q.size(); k++) begin
      eb = ((k / 8) % 4) * 8 + (k % 8);
      er = (k / 8) / 4;
      n_cmp++;
      if (hs_q[k].bram !== 5'(eb) || hs_q[k].row !== 4'(er) || hs_q[k].i !== 3'(k % 8) ||
          hs_q[k].j !== 6'(k / 8) || hs_q[k].last !== (k == 39)) begin
        n_bad++;
        $display("FAIL multi_req%0d: got bram=%0d row=%0d i=%0d j=%0d last=%0b want %0d %0d %0d %0d %0b",
                 k, hs_q[k].bram, hs_q[k].row, hs_q[k].i, hs_q[k].j, hs_q[k].last,
                 eb, er, k % 8, k / 8, (k == 39));
      end
    end
    if (hs_q.size() == 40) begin
      n_cmp++; if (hs_q[8].bram !== 5'd8 || hs_q[8].row !== 4'd0) begin n_bad++; $display("FAIL multi_req9: got bram=%0d row=%0d want 8 0", hs_q[8].bram, hs_q[8].row); end
      n_cmp++; if (hs_q[32].bram !== 5'd0 || hs_q[32].row !== 4'd1) begin n_bad++; $display("FAIL multi_req33: got bram=%0d row=%0d want 0 1", hs_q[32].bram, hs_q[32].row); end
      n_cmp++; if (hs_q[39].bram !== 5'd7 || hs_q[39].row !== 4'd1 || hs_q[39].last !== 1'b1) begin n_bad++; $display("FAIL multi_req40: got bram=%0d row=%0d last=%0b want 7 1 1", hs_q[39].bram, hs_q[39].row, hs_q[39].last); end
      n_cmp++; if (hs_cyc[39] != 39) begin n_bad++; $display("FAIL multi_gapless: got cyc=%0d want 39", hs_cyc[39]); end
    end
    n_cmp++; if (log_q[40].done !== 1'b1 || count_done() != 1) begin n_bad++; $display("FAIL multi_done: got done=%0b count=%0d want 1 1", log_q[40].done, count_done()); end
  endtask

  task automatic test_stall();
    int n_stall = 0;
    kick(6'd1);
    run(16, 3, 3, -1, -1);
    extract();
    foreach (log_q[c]) begin
      if (!log_q[c].ready) begin
        n_stall++;
        n_cmp++;
        if (log_q[c].valid !== 1'b1 || log_q[c].bram !== 5'd3 || log_q[c].i !== 3'd3) begin
          n_bad++;
          $display("FAIL stall_hold_c%0d: got valid=%0b bram=%0d i=%0d want 1 3 3", c, log_q[c].valid, log_q[c].bram, log_q[c].i);
        end
      end
    end
    n_cmp++; if (n_stall != 3) begin n_bad++; $display("FAIL stall_cycles: got %0d want 3", n_stall); end
    n_cmp++; if (hs_q.size() != 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", hs_q.size()); end
    for (int k = 0; k < 8 && k < hs_q.size(); k++) begin
      n_cmp++;
      if (hs_q[k].bram !== 5'(k) || hs_cyc[k] != k + ((k >= 3) ? 3 : 0)) begin
        n_bad++;
        $display("FAIL stall_req%0d: got bram=%0d cyc=%0d want %0d %0d", k, hs_q[k].bram, hs_cyc[k], k, k + ((k >= 3) ? 3 : 0));
      end
    end
    n_cmp++; if (log_q[11].done !== 1'b1 || count_done() != 1) begin n_bad++; $display("FAIL stall_done: got done=%0b count=%0d want 1 1", log_q[11].done, count_done()); end
  endtask

  task automatic test_ignore_start();
    kick(6'd2);
    run(22, -1, 0, 5, -1);
    extract();
    n_cmp++; if (hs_q.size() != 16) begin n_bad++; $display("FAIL ignore_count: got %0d want 16", hs_q.size()); end
    for (int k = 0; k < 16 && k < hs_q.size(); k++) begin
      n_cmp++;
      if (hs_q[k].bram !== 5'(((k / 8) % 4) * 8 + (k % 8)) || hs_q[k].last !== (k == 15)) begin
        n_bad++;
        $display("FAIL ignore_req%0d: got bram=%0d last=%0b want %0d %0b", k, hs_q[k].bram, hs_q[k].last, ((k / 8) % 4) * 8 + (k % 8), (k == 15));
      end
    end
    n_cmp++; if (count_done() != 1 || log_q[16].done !== 1'b1) begin n_bad++; $display("FAIL ignore_done: got count=%0d done16=%0b want 1 1", count_done(), log_q[16].done); end
    n_cmp++; if (log_q[21].valid !== 1'b0 || log_q[21].busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle: got valid=%0b busy=%0b want 0 0", log_q[21].valid, log_q[21].busy); end
  endtask

  task automatic test_zero();
    kick(6'd0);
    run(4, -1, 0, -1, -1);
    extract();
    n_cmp++; if (hs_q.size() != 0 || log_q[0].valid !== 1'b0) begin n_bad++; $display("FAIL zero_noreq: got reqs=%0d valid0=%0b want 0 0", hs_q.size(), log_q[0].valid); end
    n_cmp++; if (log_q[0].busy !== 1'b1 || log_q[0].done !== 1'b1) begin n_bad++; $display("FAIL zero_finish: got busy=%0b done=%0b want 1 1", log_q[0].busy, log_q[0].done); end
    n_cmp++; if (log_q[1].busy !== 1'b0 || log_q[1].done !== 1'b0) begin n_bad++; $display("FAIL zero_idle: got busy=%0b done=%0b want 0 0", log_q[1].busy, log_q[1].done); end
  endtask

  task automatic test_reset_mid();
    kick(6'd2);
    run(8, -1, 0, -1, 5);
    extract();
    n_cmp++; if (hs_q.size() != 5) begin n_bad++; $display("FAIL rstmid_count: got %0d want 5", hs_q.size()); end
    n_cmp++; if (log_q[6].valid !== 1'b0 || log_q[6].busy !== 1'b0 || log_q[6].done !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got valid=%0b busy=%0b done=%0b want 0 0 0", log_q[6].valid, log_q[6].busy, log_q[6].done); end
    n_cmp++; if (count_done() != 0) begin n_bad++; $display("FAIL rstmid_nodone: got %0d want 0", count_done()); end
    kick(6'd1);
    run(12, -1, 0, -1, -1);
    extract();
    n_cmp++; if (hs_q.size() != 8) begin n_bad++; $display("FAIL rstmid_fresh_count: got %0d want 8", hs_q.size()); end
    for (int k = 0; k < 8 && k < hs_q.size(); k++) begin
      n_cmp++;
      if (hs_q[k].bram !== 5'(k) || hs_q[k].j !== 6'd0) begin
        n_bad++;
        $display("FAIL rstmid_fresh_req%0d: got bram=%0d j=%0d want %0d 0", k, hs_q[k].bram, hs_q[k].j, k);
      end
    end
    n_cmp++; if (count_done() != 1) begin n_bad++; $display("FAIL rstmid_fresh_done: got %0d want 1", count_done()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_ignore_start();
    test_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
